// File: rtl/cpu_mem_arbiter.sv
// Arbitrates instruction-fetch (I) and load/store (D) requesters onto one memory port, with watchdog abort.
// Define CPU_MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority with D over I.
module cpu_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state, state_nxt;
    logic          owner_d;
    logic [CW-1:0] wd_cnt;
    logic          grant_i, grant_d, hs, done, wd_hit;
`ifdef CPU_MEM_ARB_RR_EN
    logic          last_d;
`endif

    always_comb begin
`ifdef CPU_MEM_ARB_RR_EN
        grant_d = d_valid & (~i_valid | ~last_d);
`else
        grant_d = d_valid;
`endif
        grant_i = i_valid & ~grant_d;
        hs      = (state == IDLE) & (grant_i | grant_d);
        done    = (state == RESP) & mem_rvalid;
        wd_hit  = (TIMEOUT_CYCLES != 0) && (state != IDLE) && (wd_cnt == CNT_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Completion in RESP takes precedence over a watchdog hit in the same cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (hs) state_nxt = REQ;
            REQ: begin
                if (wd_hit)         state_nxt = IDLE;
                else if (mem_ready) state_nxt = RESP;
            end
            RESP: if (done || wd_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_ready   = (state == IDLE) & grant_i;
        d_ready   = (state == IDLE) & grant_d;
        mem_valid = (state == REQ) & ~wd_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d   <= 1'b0;
            wd_cnt    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            i_rvalid  <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
`ifdef CPU_MEM_ARB_RR_EN
            last_d    <= 1'b1;
`endif
        end else begin
            i_rvalid <= 1'b0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            if (hs) begin
                owner_d   <= grant_d;
                wd_cnt    <= '0;
                mem_addr  <= grant_d ? d_addr : i_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
                mem_wstrb <= grant_d ? d_wstrb : '0;
`ifdef CPU_MEM_ARB_RR_EN
                last_d    <= grant_d;
`endif
            end else if (state != IDLE && wd_cnt != '1) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (done) begin
                if (owner_d) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= mem_rdata;
                end else begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= mem_rdata;
                end
            end else if (wd_hit) begin
                if (owner_d) begin
                    d_rvalid <= 1'b1;
                    d_err    <= 1'b1;
                    d_rdata  <= '0;
                end else begin
                    i_rvalid <= 1'b1;
                    i_err    <= 1'b1;
                    i_rdata  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed cases plus randomized transactions vs a transaction-level model.
module tb_cpu_mem_arbiter;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_valid, d_ready, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_valid, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_i_rdata, exp_d_rdata;
`ifdef CPU_MEM_ARB_RR_EN
    bit          m_last_d;
`endif

    cpu_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // True when D should win the grant given the current request pattern.
    function automatic bit pick_d(input bit iv, input bit dv);
`ifdef CPU_MEM_ARB_RR_EN
        if (iv && dv) return !m_last_d;
`endif
        return dv;
    endfunction

    task automatic model_reset();
        exp_i_rdata = '0;
        exp_d_rdata = '0;
`ifdef CPU_MEM_ARB_RR_EN
        m_last_d = 1'b1;
`endif
    endtask

    task automatic check_reset_values();
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        check("rst_i_rvalid",  i_rvalid,  0);
        check("rst_d_rvalid",  d_rvalid,  0);
        check("rst_i_err",     i_err,     0);
        check("rst_d_err",     d_err,     0);
        check("rst_i_rdata",   i_rdata,   0);
        check("rst_d_rdata",   d_rdata,   0);
        check("rst_i_ready",   i_ready,   0);
        check("rst_d_ready",   d_ready,   0);
    endtask

    // One transaction: handshake at c=0; memory raises mem_ready at c=1+r (one cycle)
    // and mem_rvalid at c=2+r+s (one cycle). Called just after a rising edge.
    task automatic do_txn(input bit iv, input bit dv,
                          input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input int unsigned r, input int unsigned s,
                          input logic [31:0] rd);
        bit          win_d, to;
        int unsigned pulse, mv_last, last;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_strb;
        win_d   = pick_d(iv, dv);
        e_addr  = win_d ? da : ia;
        e_wdata = win_d ? wd : 32'h0;
        e_strb  = win_d ? ws : 4'h0;
        // Watchdog counter reads c-1 at cycle c; it fires when it equals T.
        if (r >= T) begin
            to = 1'b1; mv_last = T; pulse = T + 2;
        end else begin
            mv_last = r + 1;
            if (r + 1 + s <= T) begin to = 1'b0; pulse = r + s + 3; end
            else begin to = 1'b1; pulse = T + 2; end
        end
        last = (pulse > r + s + 2) ? pulse : r + s + 2;

        i_valid = iv; d_valid = dv; i_addr = ia; d_addr = da;
        d_wdata = wd; d_wstrb = ws; mem_rdata = rd;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        check("grant_i_ready", i_ready, iv && !win_d);
        check("grant_d_ready", d_ready, win_d);
`ifdef CPU_MEM_ARB_RR_EN
        m_last_d = win_d;
`endif
        @(posedge clk); #1;
        if (win_d) d_valid = 1'b0; else i_valid = 1'b0;

        for (int unsigned c = 1; c <= last; c++) begin
            mem_ready  = (c == r + 1);
            mem_rvalid = (c == r + s + 2);
            if (c >= pulse) begin i_valid = 1'b0; d_valid = 1'b0; end
            @(negedge clk);
            if (c == pulse) begin
                if (win_d) exp_d_rdata = to ? 32'h0 : rd;
                else       exp_i_rdata = to ? 32'h0 : rd;
            end
            check("mem_valid", mem_valid, c <= mv_last);
            if (c <= mv_last) begin
                check("mem_addr",  mem_addr,  e_addr);
                check("mem_wdata", mem_wdata, e_wdata);
                check("mem_wstrb", mem_wstrb, e_strb);
            end
            check("busy_i_ready", i_ready, 0);
            check("busy_d_ready", d_ready, 0);
            check("i_rvalid", i_rvalid, (c == pulse) && !win_d);
            check("i_err",    i_err,    (c == pulse) && !win_d && to);
            check("d_rvalid", d_rvalid, (c == pulse) && win_d);
            check("d_err",    d_err,    (c == pulse) && win_d && to);
            check("i_rdata",  i_rdata,  exp_i_rdata);
            check("d_rdata",  d_rdata,  exp_d_rdata);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        bit          iv, dv;
        int unsigned pat, r, s;
        rst = 1'b1;
        i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_addr = '0;
        d_wdata = '0; d_wstrb = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;

        // Contention straight out of reset: four ties.
        for (int k = 0; k < 4; k++)
            do_txn(1'b1, 1'b1, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 32'hA5A5_0000 + 32'(k),
                   4'hF, 0, 0, 32'hC0DE_0000 + 32'(k));

        do_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF);
        do_txn(1'b0, 1'b1, 32'h0, 32'h2004, 32'h1234_5678, 4'b0011, 2, 0, 32'h5555_AAAA);
        do_txn(1'b0, 1'b1, 32'h0, 32'h40, 32'h0, 4'h0, 3, 4, 32'h0BAD_F00D);
        do_txn(1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 4'h0, 3, 5, 32'h1111_2222);
        do_txn(1'b1, 1'b0, 32'h48, 32'h0, 32'h0, 4'h0, 20, 0, 32'h3333_4444);

        // Reset while waiting in RESP; the memory response arrives during the reset cycle.
        i_valid = 1'b1; i_addr = 32'h300; mem_rdata = 32'h7777_8888;
        @(negedge clk);
        check("rr_setup_i_ready", i_ready, 1);
        @(posedge clk); #1;
        i_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0; rst = 1'b1; mem_rvalid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b0;
        model_reset();
        #2;
        check_reset_values();
        do_txn(1'b1, 1'b1, 32'h500, 32'h600, 32'hFEED_FACE, 4'b1000, 0, 1, 32'h9999_0000);

        for (int k = 0; k < 40; k++) begin
            pat = $urandom_range(1, 3);
            iv  = pat[0];
            dv  = pat[1];
            r   = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 10) : $urandom_range(0, 3);
            s   = $urandom_range(0, 5);
            do_txn(iv, dv, $urandom, $urandom, $urandom, 4'($urandom), r, s, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shares one 32-bit memory port between the CPU's instruction-fetch requester (I) and data load/store requester (D), so a multi-cycle core can run from a single unified RAM. One transaction is outstanding at a time; a three-state FSM (IDLE/REQ/RESP) sequences the grant, the memory handshake and the response return. A watchdog aborts transactions the memory never completes and flags them with an error response.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles spent in REQ+RESP before abort; 0 disables the watchdog.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_valid` / `d_valid` in 1: requester has a request.
- `i_addr` / `d_addr` in 32: byte address.
- `d_wdata` in 32: store data.
- `d_wstrb` in 4: byte write enables; 0 means read. I is always read (wstrb 0, wdata 0).
- `i_ready` / `d_ready` out 1: request accepted this cycle.
- `i_rvalid` / `d_rvalid` out 1: one-cycle response pulse.
- `i_rdata` / `d_rdata` out 32: response data.
- `i_err` / `d_err` out 1: qualifies rvalid; 1 means timed out.
- `mem_valid` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_wstrb` out 4: memory request.
- `mem_ready` in 1: memory accepts request.
- `mem_rvalid` in 1, `mem_rdata` in 32: memory response, issued for reads and writes.

## Operation
- IDLE: grant selected combinationally from `i_valid`/`d_valid`. The winner's `*_ready` = 1 in the same cycle. The loser's ready = 0 and it must hold its request stable.
- On handshake: latch addr/wdata/wstrb and owner ID, clear the watchdog counter, go to REQ.
- REQ: `mem_valid` = 1 with the latched fields. On `mem_ready` go to RESP. Fields stay stable until accepted.
- RESP: `mem_valid` = 0. On `mem_rvalid`, register `mem_rdata` into the owner's rdata, pulse the owner's rvalid next cycle with err = 0, and go to IDLE.
- Non-owner rvalid/err are always 0. `*_rdata` holds its last value between pulses.
- Watchdog (`TIMEOUT_CYCLES` > 0): counter increments every cycle in REQ or RESP. When the counter equals `TIMEOUT_CYCLES` and the transaction has not completed:
  - drop `mem_valid`;
  - pulse the owner's rvalid with err = 1 and rdata = 0 next cycle;
  - go to IDLE.
- Completion and timeout in the same cycle: completion wins.
- `mem_rvalid` in IDLE or REQ is ignored, including late responses after an abort.
- `mem_ready` outside REQ is ignored.
- Counter width is clog2(`TIMEOUT_CYCLES`+1); it saturates and never wraps.

## Timing
- Reset values: state IDLE; `mem_valid` 0; `mem_addr`, `mem_wdata`, `mem_wstrb`, `*_rdata` 0; `*_rvalid` and `*_err` 0; round-robin pointer = D last granted.
- Reset mid-transaction: state returns to IDLE and no response pulse is produced.
- Zero-wait memory (mem_ready in the first REQ cycle, mem_rvalid in the first RESP cycle):
  - handshake at cycle N;
  - `mem_valid` at N+1;
  - RESP at N+2;
  - rvalid pulse and IDLE at N+3;
  - next handshake possible at N+3.
- Peak throughput is one transaction per 3 cycles.
- The ready outputs are combinational from `*_valid` and state. No other output is combinational from inputs.

## Configuration
- `CPU_MEM_ARB_RR_EN` defined: round-robin arbitration. On a tie, the requester not granted last wins. The pointer updates only on a handshake.
- Not defined: fixed priority, D over I. I can be starved while `d_valid` stays high; this is acceptable because the core never asserts `d_valid` continuously.

## Test plan
- Single read: `i_valid`=1, `i_addr`=0x100; memory zero-wait, `mem_rdata`=0xDEADBEEF.
  - Expect `i_ready` at cycle 0, `mem_addr`=0x100 and `mem_wstrb`=0 at cycle 1.
  - Expect `i_rvalid`=1, `i_rdata`=0xDEADBEEF, `i_err`=0 at cycle 3.
- Store: `d_addr`=0x2004, `d_wdata`=0x12345678, `d_wstrb`=4'b0011; memory stalls `mem_ready` 2 cycles.
  - Expect `mem_valid` held 3 cycles with stable fields.
  - Expect `d_rvalid` one cycle after `mem_rvalid`, and no pulse on `i_rvalid`.
- Contention, both valid continuously for 4 transactions:
  - without the macro, expect grants D,D,D,D;
  - with `CPU_MEM_ARB_RR_EN`, expect I,D,I,D.
- Timeout: `TIMEOUT_CYCLES`=8, memory never asserts `mem_ready`.
  - Expect `mem_valid` to drop after 8 REQ cycles, then `i_rvalid`=1, `i_err`=1, `i_rdata`=0.
  - A later stray `mem_rvalid` produces no pulse.
- Reset in RESP: assert `rst` for 1 cycle while waiting for `mem_rvalid`.
  - Expect all outputs at reset values and no rvalid pulse.
  - Expect a new request accepted the cycle after `rst` deasserts.
